// File: rtl/instr_decode_calc_pipe_pkg.sv
// rtl/instr_decode_calc_pipe_pkg.sv - shared ALU opcode set, RISC-V calc encodings, decoded-entry type
package instr_decode_calc_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_NOP  = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Everything about an entry except the XLEN-wide immediate, which is stored separately.
  typedef struct packed {
    alu_op_e    alu_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_imm;
    logic       illegal;
  } dec_meta_t;

  localparam dec_meta_t META_RESET = '{alu_op: ALU_NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                       use_imm: 1'b0, illegal: 1'b0};

  // funct3 to opcode for the base (funct7 = 0) encodings; funct3 101 maps to the logical shift.
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/calc_decode_comb.sv
// rtl/calc_decode_comb.sv - combinational decode of OP / OP-IMM calc instructions
module calc_decode_comb
  import instr_decode_calc_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_meta_t       meta,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shamt_ok;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // A 6-bit shift amount is only meaningful on a 64-bit datapath.
  assign shamt_ok = (XLEN == 64) || !instr[25];

  always_comb begin
    meta.alu_op  = ALU_NOP;
    meta.rd      = instr[11:7];
    meta.rs1     = instr[19:15];
    meta.rs2     = instr[24:20];
    meta.use_imm = 1'b0;
    meta.illegal = 1'b1;
    imm          = '0;
    case (opcode)
      OPC_OP_IMM: begin
        case (f3)
          F3_SLL: begin
            if (instr[31:26] == 6'b000000 && shamt_ok) begin
              meta.alu_op  = ALU_SLL;
              meta.use_imm = 1'b1;
              meta.illegal = 1'b0;
              imm          = XLEN'(instr[25:20]);
            end
          end
          F3_SR: begin
            if ((instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000) && shamt_ok) begin
              meta.alu_op  = instr[30] ? ALU_SRA : ALU_SRL;
              meta.use_imm = 1'b1;
              meta.illegal = 1'b0;
              imm          = XLEN'(instr[25:20]);
            end
          end
          default: begin
            meta.alu_op  = f3_to_alu(f3);
            meta.use_imm = 1'b1;
            meta.illegal = 1'b0;
            imm          = {{(XLEN-12){instr[31]}}, instr[31:20]};
          end
        endcase
      end
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          meta.alu_op  = f3_to_alu(f3);
          meta.illegal = 1'b0;
        end else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) begin
          meta.alu_op  = (f3 == F3_ADD) ? ALU_SUB : ALU_SRA;
          meta.illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_decode_calc_pipe.sv
// rtl/instr_decode_calc_pipe.sv - decode stage with 2-entry main/skid FIFO and illegal counter
module instr_decode_calc_pipe
  import instr_decode_calc_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_use_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_meta_t       dec_meta;
  logic [XLEN-1:0] dec_imm;
  dec_meta_t       main_meta, skid_meta;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [1:0]      count;
  logic            push, pop;

  calc_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .meta  (dec_meta),
    .imm   (dec_imm)
  );

  // Handshake flags depend only on the occupancy register, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      main_meta <= META_RESET;
      skid_meta <= META_RESET;
      main_imm  <= '0;
      skid_imm  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            main_meta <= dec_meta;
            main_imm  <= dec_imm;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            main_meta <= dec_meta;
            main_imm  <= dec_imm;
          end else if (push) begin
            skid_meta <= dec_meta;
            skid_imm  <= dec_imm;
            count     <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            main_meta <= skid_meta;
            main_imm  <= skid_imm;
            count     <= 2'd1;
          end
        end
      endcase
    end
  end

  // Counts at accept regardless of a same-edge flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && dec_meta.illegal && illegal_cnt != {CNT_W{1'b1}}) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_alu_op  = main_meta.alu_op;
  assign out_rd      = main_meta.rd;
  assign out_rs1     = main_meta.rs1;
  assign out_rs2     = main_meta.rs2;
  assign out_use_imm = main_meta.use_imm;
  assign out_illegal = main_meta.illegal;
  assign out_imm     = main_imm;

endmodule

// File: tb/tb_instr_decode_calc_pipe.sv
// tb/tb_instr_decode_calc_pipe.sv - randomized and directed bench against a queue-based reference model
module tb_instr_decode_calc_pipe;
  import instr_decode_calc_pipe_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        use_imm;
    logic        ill;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;

  logic a_in_ready, a_out_valid, a_use_imm, a_illegal;
  logic [3:0] a_alu_op;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [31:0] a_imm;
  logic [15:0] a_cnt;

  logic b_in_ready, b_out_valid, b_use_imm, b_illegal;
  logic [3:0] b_alu_op;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [63:0] b_imm;
  logic [15:0] b_cnt;

  logic c_in_ready, c_out_valid, c_use_imm, c_illegal;
  logic [3:0] c_alu_op;
  logic [4:0] c_rd, c_rs1, c_rs2;
  logic [31:0] c_imm;
  logic [1:0] c_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  logic [31:0] last_w = 32'h0;
  bit last_valid = 1'b0;
  int ill32 = 0;
  int ill64 = 0;

  always #5 clk = ~clk;

  instr_decode_calc_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready), .out_alu_op(a_alu_op),
    .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm), .out_use_imm(a_use_imm),
    .out_illegal(a_illegal), .illegal_cnt(a_cnt));

  instr_decode_calc_pipe #(.XLEN(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready), .out_alu_op(b_alu_op),
    .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm), .out_use_imm(b_use_imm),
    .out_illegal(b_illegal), .illegal_cnt(b_cnt));

  instr_decode_calc_pipe #(.XLEN(32), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .out_valid(c_out_valid), .out_ready(out_ready), .out_alu_op(c_alu_op),
    .out_rd(c_rd), .out_rs1(c_rs1), .out_rs2(c_rs2), .out_imm(c_imm), .out_use_imm(c_use_imm),
    .out_illegal(c_illegal), .illegal_cnt(c_cnt));

  function automatic ent_t ref_decode(input logic [31:0] w, input int xlen);
    ent_t e;
    logic [3:0] base [0:7];
    logic [2:0] f3;
    logic [5:0] upper;
    int shamt;
    bit ok;
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = w[14:12];
    upper = w[31:26];
    shamt = int'(w[25:20]);
    e = '0;
    e.op = ALU_NOP;
    e.ill = 1'b1;
    e.rd = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    if (w[6:0] == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        ok = (shamt < xlen) && (upper == 6'h00 || (f3 == 3'd5 && upper == 6'h10));
        if (ok) begin
          e.op = (f3 == 3'd1) ? ALU_SLL : ((upper == 6'h10) ? ALU_SRA : ALU_SRL);
          e.imm = 64'(shamt);
          e.use_imm = 1'b1;
          e.ill = 1'b0;
        end
      end else begin
        e.op = base[f3];
        e.imm = {{52{w[31]}}, w[31:20]};
        e.use_imm = 1'b1;
        e.ill = 1'b0;
      end
    end else if (w[6:0] == 7'h33) begin
      if (w[31:25] == 7'h00) begin
        e.op = base[f3];
        e.ill = 1'b0;
      end else if (w[31:25] == 7'h20 && f3 == 3'd0) begin
        e.op = ALU_SUB;
        e.ill = 1'b0;
      end else if (w[31:25] == 7'h20 && f3 == 3'd5) begin
        e.op = ALU_SRA;
        e.ill = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic ent_t head_exp(input int xlen);
    ent_t e;
    if (q.size() > 0) return ref_decode(q[0], xlen);
    if (last_valid) return ref_decode(last_w, xlen);
    e = '0;
    e.op = ALU_NOP;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    ent_t ea, eb;
    ea = head_exp(32);
    eb = head_exp(64);
    chk("a_in_ready", a_in_ready, q.size() < 2);
    chk("a_out_valid", a_out_valid, q.size() > 0);
    chk("a_alu_op", a_alu_op, ea.op);
    chk("a_rd", a_rd, ea.rd);
    chk("a_rs1", a_rs1, ea.rs1);
    chk("a_rs2", a_rs2, ea.rs2);
    chk("a_imm", a_imm, ea.imm[31:0]);
    chk("a_use_imm", a_use_imm, ea.use_imm);
    chk("a_illegal", a_illegal, ea.ill);
    chk("a_cnt", a_cnt, (ill32 > 65535) ? 65535 : ill32);
    chk("b_out_valid", b_out_valid, q.size() > 0);
    chk("b_in_ready", b_in_ready, q.size() < 2);
    chk("b_alu_op", b_alu_op, eb.op);
    chk("b_imm", b_imm, eb.imm);
    chk("b_illegal", b_illegal, eb.ill);
    chk("b_cnt", b_cnt, (ill64 > 65535) ? 65535 : ill64);
    chk("c_out_valid", c_out_valid, q.size() > 0);
    chk("c_alu_op", c_alu_op, ea.op);
    chk("c_cnt", c_cnt, (ill32 > 3) ? 3 : ill32);
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    bit acc, emt;
    in_valid = v;
    in_instr = w;
    out_ready = ordy;
    flush = fl;
    acc = v && (q.size() < 2);
    emt = (q.size() > 0) && ordy;
    @(posedge clk);
    if (acc && ref_decode(w, 32).ill) ill32++;
    if (acc && ref_decode(w, 64).ill) ill64++;
    if (fl) q.delete();
    else begin
      if (emt) q.delete(0);
      if (acc) q.push_back(w);
    end
    if (q.size() > 0) begin
      last_w = q[0];
      last_valid = 1'b1;
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    logic [5:0] ups [0:2];
    logic [6:0] f7s [0:2];
    ups = '{6'h00, 6'h10, 6'h00};
    f7s = '{7'h00, 7'h20, 7'h00};
    w = $urandom;
    sel = $urandom_range(0, 9);
    ups[2] = w[31:26] ^ 6'(sel);
    f7s[2] = 7'($urandom);
    if (sel < 4) begin
      w[6:0] = 7'h13;
      if (w[12]) w[31:26] = ups[$urandom_range(0, 2)];
    end else if (sel < 7) begin
      w[6:0] = 7'h33;
      w[31:25] = f7s[$urandom_range(0, 2)];
    end
    return w;
  endfunction

  initial begin
    @(negedge clk);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    check_model();

    // addi x2,x1,-1
    step(1'b1, 32'hFFF08113, 1'b1, 1'b0);
    chk("addi_valid", a_out_valid, 1);
    chk("addi_op", a_alu_op, ALU_ADD);
    chk("addi_rd", a_rd, 2);
    chk("addi_rs1", a_rs1, 1);
    chk("addi_imm", a_imm, 32'hFFFFFFFF);
    chk("addi_use", a_use_imm, 1);

    // srai x10,x1,5 then sub x3,x1,x2
    step(1'b1, 32'h4050D513, 1'b1, 1'b0);
    chk("srai_op", a_alu_op, ALU_SRA);
    chk("srai_imm", a_imm, 5);
    chk("srai_use", a_use_imm, 1);
    step(1'b1, 32'h402081B3, 1'b1, 1'b0);
    chk("sub_op", a_alu_op, ALU_SUB);
    chk("sub_rs2", a_rs2, 2);
    chk("sub_use", a_use_imm, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_valid", a_out_valid, 0);

    // slli x5,x6,37: illegal on 32-bit, legal on 64-bit
    step(1'b1, 32'h02531293, 1'b1, 1'b0);
    chk("slli32_ill", a_illegal, 1);
    chk("slli32_op", a_alu_op, ALU_NOP);
    chk("slli32_cnt", a_cnt, 1);
    chk("slli64_op", b_alu_op, ALU_SLL);
    chk("slli64_imm", b_imm, 37);
    chk("slli64_ill", b_illegal, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // backpressure: two accepted, third refused, then drained in order
    step(1'b1, 32'h00100213, 1'b0, 1'b0);
    step(1'b1, 32'h0020C2B3, 1'b0, 1'b0);
    chk("full_in_ready", a_in_ready, 0);
    step(1'b1, 32'h0020E333, 1'b0, 1'b0);
    chk("full_head_rd", a_rd, 4);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain1_rd", a_rd, 5);
    chk("drain1_op", a_alu_op, ALU_XOR);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain2_valid", a_out_valid, 0);

    // flush while full, then flush with a same-edge illegal accept
    step(1'b1, 32'h00100213, 1'b0, 1'b0);
    step(1'b1, 32'h0020C2B3, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    chk("flush_valid", a_out_valid, 0);
    chk("flush_in_ready", a_in_ready, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_emit", a_out_valid, 0);
    step(1'b1, 32'h00100213, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    chk("flush_acc_cnt", a_cnt, 2);
    chk("flush_acc_valid", a_out_valid, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    end

    // saturate the 2-bit counter, then reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("sat_c_cnt", c_cnt, 3);
    step(1'b1, 32'h00100213, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    last_valid = 1'b0;
    ill32 = 0;
    ill64 = 0;
    check_model();
    chk("rst_c_cnt", c_cnt, 0);
    chk("rst_a_op", a_alu_op, ALU_NOP);
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
    step(1'b1, 32'hFFF08113, 1'b1, 1'b0);
    chk("post_rst_valid", a_out_valid, 1);
    chk("post_rst_rd", a_rd, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
